id_scoreboard: RTL

Register-write scoreboard for the non-forwarding pipeline. It tracks which destination registers are still in flight in EX, MEM and WB, and raises a combinational stall for the instruction in ID when it reads one of them. It sits between the ID stage and the hazard detection unit. Its stall output replaces the single-stage rd/rs compare, so RAW hazards against MEM and WB writers are also covered. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/id_scoreboard.sv | 119 +++++++++++
 1 files changed

// File: rtl/id_scoreboard.sv
// Register-write scoreboard for a non-forwarding pipeline: tracks destination
// registers in flight after ID and stalls the ID instruction on a RAW hazard.
module id_scoreboard #(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_instr_id,
    input  logic             i_id_valid,
    input  logic             i_flush,
    output logic             o_stall,
    output logic [31:0]      o_busy,
    output logic [DEPTH-1:0] o_slot_valid,
    output logic [31:0]      o_stall_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // With a write-before-read register file the WB slot cannot cause a hazard.
    localparam int CMP_N = WB_BYPASS ? DEPTH - 1 : DEPTH;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       rd_d [DEPTH];
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, writes_rd;
    logic       hit_rs1, hit_rs2;
    logic       unused_instr_bits;

    assign opcode = i_instr_id[6:0];
    assign rs1    = i_instr_id[19:15];
    assign rs2    = i_instr_id[24:20];
    assign rd     = i_instr_id[11:7];
    assign unused_instr_bits = ^{i_instr_id[31:25], i_instr_id[14:12]};

    always_comb begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: rs1_used = 1'b0;
            default:                  rs1_used = 1'b1;
        endcase
        case (opcode)
            OP_R, OP_STORE, OP_BR: rs2_used = 1'b1;
            default:               rs2_used = 1'b0;
        endcase
        case (opcode)
            OP_R, OP_IALU, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
            default:                                                   writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((k < CMP_N) && valid_q[k]) begin
                if (rd_q[k] == rs1) hit_rs1 = 1'b1;
                if (rd_q[k] == rs2) hit_rs2 = 1'b1;
            end
        end
        hit_rs1 = hit_rs1 & rs1_used & (rs1 != 5'd0);
        hit_rs2 = hit_rs2 & rs2_used & (rs2 != 5'd0);
    end

    // A flush squashes the ID instruction, so it must never stall.
    assign o_stall = i_id_valid & ~i_flush & (hit_rs1 | hit_rs2);

    always_comb begin
        o_busy = 32'h0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[k]) o_busy[rd_q[k]] = 1'b1;
        end
        o_busy[0] = 1'b0;
    end

    always_comb begin
        valid_d[0] = i_id_valid & ~o_stall & ~i_flush & writes_rd & (rd != 5'd0);
        rd_d[0]    = rd;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            rd_d[k]    = rd_q[k-1];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q     <= '0;
            stall_cnt_q <= 32'h0;
            for (int k = 0; k < DEPTH; k++) rd_q[k] <= 5'd0;
        end else begin
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < DEPTH; k++) rd_q[k] <= rd_d[k];
        end
    end

    assign o_slot_valid = valid_q;
    assign o_stall_cnt  = stall_cnt_q;

endmodule
